// File: rtl/sram16_pkg.sv
// sram16_pkg: shared types and constants for the 16-bit SRAM responder.
package sram16_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Half-word select: low half carries CPU lanes 0/1, high half lanes 2/3.
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  // Within a half's 2-bit slice of wren, bit 0 drives LB and bit 1 drives UB.
  localparam int LANE_LB = 0;
  localparam int LANE_UB = 1;

  // A read always needs both halves; a write needs a half only if one of
  // its two byte lanes is enabled.
  function automatic logic half_needed(input logic [3:0] mask, input logic half);
    logic need;
    need = 1'b1;
    if (mask != 4'h0) begin
      need = half ? (|mask[3:2]) : (|mask[1:0]);
    end
    return need;
  endfunction

endpackage

// File: rtl/sram16_responder.sv
// sram16_responder: bridges a 32-bit lane-aligned CPU request onto an
// asynchronous 16-bit SRAM using one or two half-word access cycles.
// Optional build macro SRAM16_RDBUF_EN adds a one-entry read buffer.
module sram16_responder
  import sram16_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-2:0] addr,
  input  logic [3:0]        wren,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

  state_t            state_reg, state_next;
  logic              half_reg, half_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic [ADDR_W-2:0] addr_reg;
  logic [3:0]        wren_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rdata_reg;
  logic              ack_reg, ack_next;
  logic              busy_reg, busy_next;
  logic [ADDR_W-1:0] sram_addr_reg, sram_addr_next;
  logic [15:0]       dq_o_reg, dq_o_next;
  logic              dq_oe_reg, dq_oe_next;
  logic              ce_n_reg, ce_n_next;
  logic              oe_n_reg, oe_n_next;
  logic              we_n_reg, we_n_next;
  logic              lb_n_reg, lb_n_next;
  logic              ub_n_reg, ub_n_next;
  logic              rd_hit;
  logic              rd_cap;
  logic              strobe_last;

  // In IDLE the request is still on the inputs; afterwards use the latched copy,
  // so the SETUP outputs can be registered on the accepting edge.
  logic [ADDR_W-2:0] cur_addr;
  logic [3:0]        cur_wren;
  logic [31:0]       cur_wdata;
  logic              cur_write;

  assign cur_addr    = (state_reg == IDLE) ? addr  : addr_reg;
  assign cur_wren    = (state_reg == IDLE) ? wren  : wren_reg;
  assign cur_wdata   = (state_reg == IDLE) ? wdata : wdata_reg;
  assign cur_write   = (cur_wren != 4'h0);
  assign strobe_last = (state_reg == STROBE) && (cnt_reg == WAIT_LAST);
  assign rd_cap      = strobe_last && (wren_reg == 4'h0);

`ifdef SRAM16_RDBUF_EN
  // The buffer keeps only valid + tag: every completed read fills it and
  // rdata always holds the last read result, so rdata is the buffered data.
  logic              buf_valid_reg;
  logic [ADDR_W-2:0] buf_tag_reg;

  assign rd_hit = (wren == 4'h0) && buf_valid_reg && (buf_tag_reg == addr);

  // Track the buffered word address; writes to it invalidate the entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_valid_reg <= 1'b0;
      buf_tag_reg   <= '0;
    end else if ((state_reg == IDLE) && req && (wren != 4'h0) && (buf_tag_reg == addr)) begin
      buf_valid_reg <= 1'b0;
    end else if (strobe_last && (wren_reg == 4'h0) && (state_next == DONE)) begin
      buf_valid_reg <= 1'b1;
      buf_tag_reg   <= addr_reg;
    end
  end
`else
  assign rd_hit = 1'b0;
`endif

  // Next-state logic: half sequencing and strobe wait counter.
  always_comb begin
    state_next = state_reg;
    half_next  = half_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (rd_hit) begin
            state_next = DONE;
          end else begin
            state_next = SETUP;
            half_next  = half_needed(wren, HALF_LO) ? HALF_LO : HALF_HI;
          end
        end
      end
      SETUP: begin
        state_next = STROBE;
        cnt_next   = 3'd0;
      end
      STROBE: begin
        if (cnt_reg == WAIT_LAST) begin
          if ((half_reg == HALF_LO) && half_needed(wren_reg, HALF_HI)) begin
            state_next = SETUP;
            half_next  = HALF_HI;
          end else begin
            state_next = DONE;
          end
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the next state; registered below so pins never glitch.
  always_comb begin
    logic [1:0] lane_mask;
    lane_mask      = half_next ? cur_wren[3:2] : cur_wren[1:0];
    sram_addr_next = sram_addr_reg;
    dq_o_next      = dq_o_reg;
    dq_oe_next     = 1'b0;
    ce_n_next      = 1'b1;
    oe_n_next      = 1'b1;
    we_n_next      = 1'b1;
    lb_n_next      = 1'b1;
    ub_n_next      = 1'b1;
    busy_next      = (state_next != IDLE);
    ack_next       = (state_next == DONE);
    case (state_next)
      SETUP: begin
        sram_addr_next = {cur_addr, half_next};
        ce_n_next      = 1'b0;
        if (cur_write) begin
          dq_o_next  = half_next ? cur_wdata[31:16] : cur_wdata[15:0];
          dq_oe_next = 1'b1;
        end
      end
      STROBE: begin
        ce_n_next = 1'b0;
        if (cur_write) begin
          dq_oe_next = 1'b1;
          we_n_next  = 1'b0;
          lb_n_next  = ~lane_mask[LANE_LB];
          ub_n_next  = ~lane_mask[LANE_UB];
        end else begin
          oe_n_next = 1'b0;
          lb_n_next = 1'b0;
          ub_n_next = 1'b0;
        end
      end
      DONE: begin
        // Keep driving write data one edge past the final we_n rise; the
        // address is simply held. Between halves the address moves on the
        // same edge as we_n rises, which async SRAMs accept (zero tWR).
        dq_oe_next = cur_write && (state_reg != IDLE);
      end
      default: ;
    endcase
  end

  // State, request latch, read capture and registered SRAM controls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      half_reg      <= HALF_LO;
      cnt_reg       <= 3'd0;
      addr_reg      <= '0;
      wren_reg      <= 4'h0;
      wdata_reg     <= 32'h0;
      rdata_reg     <= 32'h0;
      ack_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      sram_addr_reg <= '0;
      dq_o_reg      <= 16'h0;
      dq_oe_reg     <= 1'b0;
      ce_n_reg      <= 1'b1;
      oe_n_reg      <= 1'b1;
      we_n_reg      <= 1'b1;
      lb_n_reg      <= 1'b1;
      ub_n_reg      <= 1'b1;
    end else begin
      state_reg     <= state_next;
      half_reg      <= half_next;
      cnt_reg       <= cnt_next;
      ack_reg       <= ack_next;
      busy_reg      <= busy_next;
      sram_addr_reg <= sram_addr_next;
      dq_o_reg      <= dq_o_next;
      dq_oe_reg     <= dq_oe_next;
      ce_n_reg      <= ce_n_next;
      oe_n_reg      <= oe_n_next;
      we_n_reg      <= we_n_next;
      lb_n_reg      <= lb_n_next;
      ub_n_reg      <= ub_n_next;
      if ((state_reg == IDLE) && req) begin
        addr_reg  <= addr;
        wren_reg  <= wren;
        wdata_reg <= wdata;
      end
      if (rd_cap) begin
        if (half_reg == HALF_HI) begin
          rdata_reg[31:16] <= sram_dq_i;
        end else begin
          rdata_reg[15:0] <= sram_dq_i;
        end
      end
    end
  end

  assign rdata      = rdata_reg;
  assign ack        = ack_reg;
  assign busy       = busy_reg;
  assign sram_addr  = sram_addr_reg;
  assign sram_dq_o  = dq_o_reg;
  assign sram_dq_oe = dq_oe_reg;
  assign sram_ce_n  = ce_n_reg;
  assign sram_oe_n  = oe_n_reg;
  assign sram_we_n  = we_n_reg;
  assign sram_lb_n  = lb_n_reg;
  assign sram_ub_n  = ub_n_reg;

endmodule

// File: tb/tb_sram16_responder.sv
// tb_sram16_responder: two responders (WAIT_CYCLES 0 and 3), each with a
// behavioural async SRAM; expected acks are queued at issue time and a
// monitor pops and compares them whenever a DUT acks.
module tb_sram16_responder;

  localparam int ADDR_W = 18;

  typedef struct {
    int          inst;
    logic        is_rd;
    logic [31:0] rd;
    int          lat;
    int          cyc;
    logic [16:0] a;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [1:0]        req;
  logic [ADDR_W-2:0] addr;
  logic [3:0]        wren;
  logic [31:0]       wdata;
  logic [31:0]       rdata [2];
  logic [1:0]        ack, busy, dq_oe, ce_n, oe_n, we_n, lb_n, ub_n;
  logic [ADDR_W-1:0] sram_addr [2];
  logic [15:0]       dq_o [2];
  logic [15:0]       dq_i [2];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ce_cnt [2] = '{0, 0};
  int oe_cnt [2] = '{0, 0};
  int oe_fall [2] = '{0, 0};
  int we_rise_bad = 0;
  logic [1:0] oe_prev = 2'b11;
  logic [1:0] we_prev = 2'b11;
  logic [36:0] wr_log [$];
  sb_t sb_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [15:0] mem [0:255];

    sram16_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(gi * 3)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req[gi]),
      .addr       (addr),
      .wren       (wren),
      .wdata      (wdata),
      .rdata      (rdata[gi]),
      .ack        (ack[gi]),
      .busy       (busy[gi]),
      .sram_addr  (sram_addr[gi]),
      .sram_dq_o  (dq_o[gi]),
      .sram_dq_oe (dq_oe[gi]),
      .sram_dq_i  (dq_i[gi]),
      .sram_ce_n  (ce_n[gi]),
      .sram_oe_n  (oe_n[gi]),
      .sram_we_n  (we_n[gi]),
      .sram_lb_n  (lb_n[gi]),
      .sram_ub_n  (ub_n[gi])
    );

    assign dq_i[gi] = (!ce_n[gi] && !oe_n[gi]) ? mem[sram_addr[gi][7:0]] : 16'h0000;

    // SRAM model: reloads the pattern {i^8'h3C, i} while reset is held.
    always @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < 256; i++) mem[i] <= {8'(i) ^ 8'h3C, 8'(i)};
      end else if (!ce_n[gi] && !we_n[gi]) begin
        if (!lb_n[gi]) mem[sram_addr[gi][7:0]][7:0]  <= dq_o[gi][7:0];
        if (!ub_n[gi]) mem[sram_addr[gi][7:0]][15:8] <= dq_o[gi][15:8];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: pin activity counters, write log, and scoreboard on ack.
  always @(negedge clk) begin
    sb_t e;
    for (int k = 0; k < 2; k++) begin
      if (!ce_n[k]) ce_cnt[k]++;
      if (!oe_n[k]) oe_cnt[k]++;
      if (!oe_n[k] && oe_prev[k]) oe_fall[k]++;
      if (!we_n[k] && we_prev[k])
        wr_log.push_back({sram_addr[k], dq_o[k], dq_oe[k], lb_n[k], ub_n[k]});
      if (rst_n && we_n[k] && !we_prev[k] && !dq_oe[k]) we_rise_bad++;
      oe_prev[k] = oe_n[k];
      we_prev[k] = we_n[k];
      if (ack[k]) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ack: inst%0d acked, required no ack", k);
        end else begin
          e = sb_q.pop_front();
          $display("[TB] inst%0d %s addr=%h lat=%0d rdata=%h", k, e.is_rd ? "rd" : "wr",
                   e.a, cyc - e.cyc, rdata[k]);
          check("ack_inst", 64'(k), 64'(e.inst));
          check("latency", 64'(cyc - e.cyc), 64'(e.lat));
          if (e.is_rd) check("rdata", 64'(rdata[k]), 64'(e.rd));
        end
      end
    end
  end

  // Issue one request at a negedge and wait (bounded) for its ack.
  task automatic issue(input int k, input logic [16:0] a, input logic [3:0] m,
                       input logic [31:0] d, input logic [31:0] erd, input int elat);
    sb_t e;
    e.inst = k; e.is_rd = (m == 4'h0); e.rd = erd; e.lat = elat; e.cyc = cyc; e.a = a;
    sb_q.push_back(e);
    addr = a; wren = m; wdata = d; req[k] = 1'b1;
    @(negedge clk);
    req[k] = 1'b0;
    for (int t = 0; t < 40 && sb_q.size() != 0; t++) @(negedge clk);
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: inst%0d addr=%h no ack, required ack at +%0d", k, a, elat);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  int n0, c0, f0;

  initial begin
    rst_n = 1'b0; req = 2'b00; addr = '0; wren = 4'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("reset_ctl", 64'({ack[k], busy[k], dq_oe[k], ce_n[k], oe_n[k], we_n[k], lb_n[k], ub_n[k]}), 64'h1F);
      check("reset_addr", 64'(sram_addr[k]), 64'h0);
      check("reset_rdata", 64'(rdata[k]), 64'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Full-word write then read back.
    n0 = wr_log.size();
    issue(0, 17'h10, 4'hF, 32'hDEADBEEF, 32'h0, 5);
    check("fw_nwr", 64'(wr_log.size() - n0), 64'd2);
    check("fw_lo", 64'(wr_log[n0]), 64'({18'h20, 16'hBEEF, 3'b100}));
    check("fw_hi", 64'(wr_log[n0 + 1]), 64'({18'h21, 16'hDEAD, 3'b100}));
    issue(0, 17'h10, 4'h0, 32'h0, 32'hDEADBEEF, 5);

    // Reset during a write strobe.
    addr = 17'h7; wren = 4'hF; wdata = 32'h11112222; req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    for (int t = 0; t < 10 && we_n[0]; t++) @(negedge clk);
    check("rst_mid_strobe", 64'(we_n[0]), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_ctl", 64'({we_n[0], dq_oe[0], ce_n[0], busy[0], ack[0]}), 64'(5'b10100));
    check("rst_mid_rdata", 64'(rdata[0]), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Byte write to lane 2, read back with neighbours untouched.
    n0 = wr_log.size();
    issue(0, 17'h20, 4'b0100, 32'h00AB0000, 32'h0, 3);
    check("byte_nwr", 64'(wr_log.size() - n0), 64'd1);
    check("byte_wr", 64'(wr_log[n0]), 64'({18'h41, 16'h00AB, 3'b101}));
    issue(0, 17'h20, 4'h0, 32'h0, 32'h7DAB7C40, 5);

    // Low half-word write.
    n0 = wr_log.size();
    issue(0, 17'h30, 4'b0011, 32'h00001234, 32'h0, 3);
    check("half_nwr", 64'(wr_log.size() - n0), 64'd1);
    check("half_wr", 64'(wr_log[n0]), 64'({18'h60, 16'h1234, 3'b100}));
    issue(0, 17'h30, 4'h0, 32'h0, 32'h5D611234, 5);

    // Three wait states on the second instance.
    c0 = oe_cnt[1]; f0 = oe_fall[1];
    issue(1, 17'h05, 4'h0, 32'h0, 32'h370B360A, 11);
    check("w3_oe_cycles", 64'(oe_cnt[1] - c0), 64'd8);
    check("w3_oe_pulses", 64'(oe_fall[1] - f0), 64'd2);

    // Repeated read, then a write that must invalidate any buffered copy.
    issue(0, 17'h10, 4'h0, 32'h0, 32'h1D211C20, 5);
    c0 = ce_cnt[0];
`ifdef SRAM16_RDBUF_EN
    issue(0, 17'h10, 4'h0, 32'h0, 32'h1D211C20, 1);
    check("rep_rd_ce", 64'(ce_cnt[0] - c0), 64'd0);
`else
    issue(0, 17'h10, 4'h0, 32'h0, 32'h1D211C20, 5);
    check("rep_rd_ce", 64'(ce_cnt[0] - c0), 64'd4);
`endif
    issue(0, 17'h10, 4'hF, 32'hCAFEF00D, 32'h0, 5);
    c0 = ce_cnt[0];
    issue(0, 17'h10, 4'h0, 32'h0, 32'hCAFEF00D, 5);
    check("post_wr_rd_ce", 64'(ce_cnt[0] - c0), 64'd4);

    check("we_rise_before_oe_drop", 64'(we_rise_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
